// File: rtl/lsu_align.sv
// Load/store alignment unit between the EX/MEM register and the data memory.
// Macro LSU_MISALIGN_EN: split misaligned accesses into byte ops; otherwise force-align and flag them.
module lsu_align (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [10:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic        mem_stall,
    output logic [2:0]  mem_op,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Opcode encodings mirror mem.vh; bit 2 clear means store.
    localparam logic [2:0] OP_SB = 3'b000;
    localparam logic [2:0] OP_SH = 3'b001;
    localparam logic [2:0] OP_SW = 3'b010;
    localparam logic [2:0] OP_LB = 3'b100;
    localparam logic [2:0] OP_LH = 3'b101;
    localparam logic [2:0] OP_LW = 3'b110;

    logic        is_load_s;
    logic        is_store_s;
    logic        is_access_s;
    logic        is_half_s;
    logic        is_word_s;
    logic        misalign_s;

    logic        load_pend_q;
    logic        load_pend_d;
    logic        resp_valid_s;
    logic [31:0] rdata_s;

    logic        busy_s;
    logic        err_s;
    logic        stall_s;
    logic [2:0]  op_s;
    logic [10:0] addr_s;
    logic [31:0] wdata_s;

    // Request decode and misalignment detect
    always_comb begin
        is_load_s   = (req_op == OP_LB) || (req_op == OP_LH) || (req_op == OP_LW);
        is_store_s  = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);
        is_access_s = req_valid && (is_load_s || is_store_s);
        is_half_s   = (req_op == OP_LH) || (req_op == OP_SH);
        is_word_s   = (req_op == OP_LW) || (req_op == OP_SW);
        if (is_half_s) begin
            misalign_s = req_addr[0];
        end else if (is_word_s) begin
            misalign_s = (req_addr[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
    end

`ifdef LSU_MISALIGN_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [2:0]  op_q;
    logic [2:0]  op_d;
    logic [10:0] addr_q;
    logic [10:0] addr_d;
    logic [31:0] wdata_q;
    logic [31:0] wdata_d;
    logic [23:0] asm_q;
    logic [23:0] asm_d;
    logic        split_done_q;
    logic        split_done_d;
    logic        op_q_word_s;
    logic        last_s;
    logic [7:0]  wbyte_s;

    // Latched-op helpers: word/halfword, final byte index, current store byte
    always_comb begin
        op_q_word_s = (op_q == OP_LW) || (op_q == OP_SW);
        last_s      = (idx_q == (op_q_word_s ? 2'd3 : 2'd1));
        case (idx_q)
            2'd0:    wbyte_s = wdata_q[7:0];
            2'd1:    wbyte_s = wdata_q[15:8];
            2'd2:    wbyte_s = wdata_q[23:16];
            default: wbyte_s = wdata_q[31:24];
        endcase
    end

    // Split FSM next state and memory-side request
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        split_done_d = 1'b0;
        load_pend_d  = 1'b0;
        busy_s       = 1'b0;
        err_s        = 1'b0;
        stall_s      = 1'b1;
        op_s         = OP_LW;
        addr_s       = 11'h000;
        wdata_s      = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (is_access_s && misalign_s) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    idx_d   = 2'd1;
                    state_d = ST_SPLIT;
                    busy_s  = 1'b1;
                    stall_s = 1'b0;
                    op_s    = is_load_s ? OP_LB : OP_SB;
                    addr_s  = req_addr;
                    wdata_s = {24'h00_0000, req_wdata[7:0]};
                end else if (is_access_s) begin
                    stall_s     = 1'b0;
                    op_s        = req_op;
                    addr_s      = req_addr;
                    wdata_s     = req_wdata;
                    load_pend_d = is_load_s;
                end else begin
                    stall_s = 1'b1;
                end
            end
            ST_SPLIT: begin
                stall_s = 1'b0;
                op_s    = op_q[2] ? OP_LB : OP_SB;
                addr_s  = addr_q + {9'h000, idx_q};
                wdata_s = {24'h00_0000, wbyte_s};
                // mem_rdata now carries the byte issued last cycle (lane idx-1)
                if (op_q[2]) begin
                    case (idx_q)
                        2'd1:    asm_d[7:0]   = mem_rdata[7:0];
                        2'd2:    asm_d[15:8]  = mem_rdata[7:0];
                        2'd3:    asm_d[23:16] = mem_rdata[7:0];
                        default: asm_d        = asm_q;
                    endcase
                end else begin
                    asm_d = asm_q;
                end
                if (last_s) begin
                    state_d      = ST_IDLE;
                    idx_d        = 2'd0;
                    split_done_d = op_q[2];
                end else begin
                    busy_s = 1'b1;
                    idx_d  = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Split FSM and latched request registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            op_q         <= OP_LW;
            addr_q       <= 11'h000;
            wdata_q      <= 32'h0000_0000;
            asm_q        <= 24'h00_0000;
            split_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            split_done_q <= split_done_d;
        end
    end

    // Load response: split reassembly with the final byte taken live, or aligned pass-through
    always_comb begin
        resp_valid_s = load_pend_q | split_done_q;
        if (split_done_q) begin
            if (op_q_word_s) begin
                rdata_s = {mem_rdata[7:0], asm_q};
            end else begin
                rdata_s = {{16{mem_rdata[7]}}, mem_rdata[7:0], asm_q[7:0]};
            end
        end else if (load_pend_q) begin
            rdata_s = mem_rdata;
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end
`else
    // Single-cycle issue; misaligned accesses are forced to natural alignment and flagged
    always_comb begin
        load_pend_d = 1'b0;
        busy_s      = 1'b0;
        err_s       = 1'b0;
        stall_s     = 1'b1;
        op_s        = OP_LW;
        addr_s      = 11'h000;
        wdata_s     = 32'h0000_0000;
        if (is_access_s) begin
            stall_s     = 1'b0;
            op_s        = req_op;
            wdata_s     = req_wdata;
            load_pend_d = is_load_s;
            err_s       = misalign_s;
            if (is_word_s) begin
                addr_s = {req_addr[10:2], 2'b00};
            end else if (is_half_s) begin
                addr_s = {req_addr[10:1], 1'b0};
            end else begin
                addr_s = req_addr;
            end
        end else begin
            stall_s = 1'b1;
        end
    end

    // Load response: memory data passes straight through
    always_comb begin
        resp_valid_s = load_pend_q;
        if (load_pend_q) begin
            rdata_s = mem_rdata;
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end
`endif

    // Aligned-load pending flag: response lands the cycle after issue
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            load_pend_q <= 1'b0;
        end else begin
            load_pend_q <= load_pend_d;
        end
    end

    // Outputs are combinational, so hold them at reset values while nrst is low
    always_comb begin
        if (!nrst) begin
            busy         = 1'b0;
            resp_valid   = 1'b0;
            resp_rdata   = 32'h0000_0000;
            misalign_err = 1'b0;
            mem_stall    = 1'b1;
            mem_op       = OP_LW;
            mem_addr     = 11'h000;
            mem_wdata    = 32'h0000_0000;
        end else begin
            busy         = busy_s;
            resp_valid   = resp_valid_s;
            resp_rdata   = rdata_s;
            misalign_err = err_s;
            mem_stall    = stall_s;
            mem_op       = op_s;
            mem_addr     = addr_s;
            mem_wdata    = wdata_s;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: table of aligned vectors plus directed split/reset sequences.
// Split sequences are exercised when LSU_MISALIGN_EN is defined, force-align checks otherwise.
module tb_lsu_align;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;
    localparam logic [2:0] LB = 3'b100;
    localparam logic [2:0] LH = 3'b101;
    localparam logic [2:0] LW = 3'b110;

    logic        clk;
    logic        nrst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign_err;
    logic        mem_stall;
    logic [2:0]  mem_op;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests;
    int n_fail;

    lsu_align dut (
        .clk          (clk),
        .nrst         (nrst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misalign_err (misalign_err),
        .mem_stall    (mem_stall),
        .mem_op       (mem_op),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: byte array, read data valid one cycle after issue
    bit   [7:0]  mem [0:2047];
    logic        poke_en;
    logic [10:0] poke_addr;
    logic [7:0]  poke_data;
    logic [10:0] a1;
    logic [10:0] a2;
    logic [10:0] a3;
    assign a1 = mem_addr + 11'd1;
    assign a2 = mem_addr + 11'd2;
    assign a3 = mem_addr + 11'd3;

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (!mem_stall) begin
            case (mem_op)
                LB: mem_rdata <= {{24{mem[mem_addr][7]}}, mem[mem_addr]};
                LH: mem_rdata <= {{16{mem[a1][7]}}, mem[a1], mem[mem_addr]};
                LW: mem_rdata <= {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
                SB: mem[mem_addr] <= mem_wdata[7:0];
                SH: begin
                    mem[mem_addr] <= mem_wdata[7:0];
                    mem[a1]       <= mem_wdata[15:8];
                end
                SW: begin
                    mem[mem_addr] <= mem_wdata[7:0];
                    mem[a1]       <= mem_wdata[15:8];
                    mem[a2]       <= mem_wdata[23:16];
                    mem[a3]       <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    typedef struct packed {
        logic        valid;
        logic [2:0]  op;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic [2:0]  exp_op;
        logic [10:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_rv;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    logic [10:0] sw_a [4] = '{11'h021, 11'h022, 11'h023, 11'h024};
    logic [31:0] sw_d [4] = '{32'h0000_00DD, 32'h0000_00CC, 32'h0000_00BB, 32'h0000_00AA};
    logic [10:0] wr_a [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [10:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        cyc();
        poke_en   = 1'b0;
    endtask

    task automatic aligned_load(input string name, input logic [2:0] op, input logic [10:0] a,
                                input logic [31:0] exp);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = 32'h0;
        @(negedge clk);
        chk({name, "_issue"}, {mem_stall, mem_op, mem_addr, busy, misalign_err},
            {1'b0, op, a, 1'b0, 1'b0});
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_resp"}, {resp_valid, resp_rdata}, {1'b1, exp});
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        n_tests   = 0;
        n_fail    = 0;
        nrst      = 1'b0;
        req_valid = 1'b0;
        req_op    = LW;
        req_addr  = 11'h000;
        req_wdata = 32'h0;
        poke_en   = 1'b0;
        poke_addr = 11'h000;
        poke_data = 8'h00;

        //                 valid op     addr     wdata          stall op  addr     wdata          rv    rdata
        vecs[0]  = '{1'b0, LW,     11'h010, 32'hDEADBEEF, 1'b1, LW, 11'h000, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b1, 3'b011, 11'h010, 32'h0000_0055, 1'b1, LW, 11'h000, 32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b1, 3'b111, 11'h020, 32'h0000_0055, 1'b1, LW, 11'h000, 32'h0,        1'b0, 32'h0};
        vecs[3]  = '{1'b1, LW,     11'h010, 32'hDEADBEEF, 1'b0, LW, 11'h010, 32'hDEADBEEF, 1'b1, 32'h8000_1234};
        vecs[4]  = '{1'b1, LB,     11'h013, 32'h0,         1'b0, LB, 11'h013, 32'h0,         1'b1, 32'hFFFF_FF80};
        vecs[5]  = '{1'b1, LH,     11'h012, 32'h0,         1'b0, LH, 11'h012, 32'h0,         1'b1, 32'hFFFF_8000};
        vecs[6]  = '{1'b1, LB,     11'h010, 32'h0,         1'b0, LB, 11'h010, 32'h0,         1'b1, 32'h0000_0034};
        vecs[7]  = '{1'b1, SH,     11'h102, 32'h0000_BEEF, 1'b0, SH, 11'h102, 32'h0000_BEEF, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, SB,     11'h7FF, 32'h0000_005A, 1'b0, SB, 11'h7FF, 32'h0000_005A, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, SW,     11'h104, 32'h0102_0304, 1'b0, SW, 11'h104, 32'h0102_0304, 1'b0, 32'h0};
        vecs[10] = '{1'b1, LW,     11'h104, 32'h0,         1'b0, LW, 11'h104, 32'h0,         1'b1, 32'h0102_0304};
        vecs[11] = '{1'b1, LH,     11'h7FE, 32'h0,         1'b0, LH, 11'h7FE, 32'h0,         1'b1, 32'h0000_5A00};
        vecs[12] = '{1'b1, LH,     11'h102, 32'h0,         1'b0, LH, 11'h102, 32'h0,         1'b1, 32'hFFFF_BEEF};

        cyc();
        @(negedge clk);
        chk("rst_ctl", {busy, resp_valid, misalign_err, mem_stall, mem_op}, {1'b0, 1'b0, 1'b0, 1'b1, LW});
        chk("rst_data", {resp_rdata, mem_addr, mem_wdata}, {32'h0, 11'h000, 32'h0});
        cyc();
        nrst = 1'b1;
        cyc();

        poke(11'h010, 8'h34);
        poke(11'h011, 8'h12);
        poke(11'h012, 8'h00);
        poke(11'h013, 8'h80);

        aligned_load("lw_010", LW, 11'h010, 32'h8000_1234);

        for (int i = 0; i < 13; i++) begin
            req_valid = vecs[i].valid;
            req_op    = vecs[i].op;
            req_addr  = vecs[i].addr;
            req_wdata = vecs[i].wdata;
            @(negedge clk);
            chk($sformatf("vec%0d_issue", i),
                {mem_stall, mem_op, mem_addr, mem_wdata, busy, misalign_err},
                {vecs[i].exp_stall, vecs[i].exp_op, vecs[i].exp_addr, vecs[i].exp_wdata, 2'b00});
            cyc();
            req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_resp", i), {resp_valid, resp_rdata}, {vecs[i].exp_rv, vecs[i].exp_rdata});
            cyc();
        end

`ifdef LSU_MISALIGN_EN
        // Misaligned word store split into four byte stores
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 11'h021;
        req_wdata = 32'hAABB_CCDD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("sw_split_b%0d", k), {mem_stall, mem_op, mem_addr, mem_wdata, busy},
                {1'b0, SB, sw_a[k], sw_d[k], (k < 3) ? 1'b1 : 1'b0});
            cyc();
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("sw_split_idle", {busy, mem_stall, resp_valid}, {1'b0, 1'b1, 1'b0});
        cyc();
        aligned_load("sw_rb_020", LW, 11'h020, 32'hBBCC_DD00);
        aligned_load("sw_rb_024", LW, 11'h024, 32'h0000_00AA);

        // Halfword load across the 0x3FF/0x400 boundary
        poke(11'h3FF, 8'h34);
        poke(11'h400, 8'h92);
        req_valid = 1'b1;
        req_op    = LH;
        req_addr  = 11'h3FF;
        @(negedge clk);
        chk("lh_b0", {mem_stall, mem_op, mem_addr, busy, resp_valid}, {1'b0, LB, 11'h3FF, 1'b1, 1'b0});
        cyc();
        @(negedge clk);
        chk("lh_b1", {mem_stall, mem_op, mem_addr, busy, resp_valid}, {1'b0, LB, 11'h400, 1'b0, 1'b0});
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("lh_resp", {resp_valid, resp_rdata}, {1'b1, 32'hFFFF_9234});
        cyc();
        @(negedge clk);
        chk("lh_pulse", {resp_valid}, {1'b0});
        cyc();

        // Word load wrapping 0x7FF -> 0x000
        poke(11'h7FE, 8'h11);
        poke(11'h7FF, 8'h22);
        poke(11'h000, 8'h33);
        poke(11'h001, 8'h44);
        req_valid = 1'b1;
        req_op    = LW;
        req_addr  = 11'h7FE;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("lw_wrap_b%0d", k), {mem_stall, mem_op, mem_addr, busy, resp_valid},
                {1'b0, LB, wr_a[k], (k < 3) ? 1'b1 : 1'b0, 1'b0});
            cyc();
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("lw_wrap_resp", {resp_valid, resp_rdata}, {1'b1, 32'h4433_2211});
        cyc();

        // Reset in the third cycle of a split word load
        req_valid = 1'b1;
        req_op    = LW;
        req_addr  = 11'h7FE;
        cyc();
        cyc();
        nrst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctl", {busy, resp_valid, misalign_err, mem_stall, mem_op}, {1'b0, 1'b0, 1'b0, 1'b1, LW});
        chk("mid_rst_data", {resp_rdata, mem_addr, mem_wdata}, {32'h0, 11'h000, 32'h0});
        cyc();
        cyc();
        nrst      = 1'b1;
        req_valid = 1'b0;
        seen      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid || busy) seen = 1'b1;
            cyc();
        end
        chk("mid_rst_quiet", {seen}, {1'b0});
        aligned_load("post_rst_lw", LW, 11'h010, 32'h8000_1234);
`else
        // Misaligned word load is force-aligned and flagged for one cycle
        req_valid = 1'b1;
        req_op    = LW;
        req_addr  = 11'h013;
        @(negedge clk);
        chk("fa_lw_issue", {mem_stall, mem_op, mem_addr, busy, misalign_err}, {1'b0, LW, 11'h010, 1'b0, 1'b1});
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("fa_lw_resp", {resp_valid, resp_rdata, misalign_err, busy}, {1'b1, 32'h8000_1234, 1'b0, 1'b0});
        cyc();

        // Misaligned word store
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 11'h022;
        req_wdata = 32'h1122_3344;
        @(negedge clk);
        chk("fa_sw_issue", {mem_stall, mem_op, mem_addr, mem_wdata, busy, misalign_err},
            {1'b0, SW, 11'h020, 32'h1122_3344, 1'b0, 1'b1});
        cyc();
        req_valid = 1'b0;
        aligned_load("fa_sw_rb", LW, 11'h020, 32'h1122_3344);

        // Misaligned halfword load
        poke(11'h3FF, 8'h9A);
        req_valid = 1'b1;
        req_op    = LH;
        req_addr  = 11'h3FF;
        @(negedge clk);
        chk("fa_lh_issue", {mem_stall, mem_op, mem_addr, busy, misalign_err}, {1'b0, LH, 11'h3FE, 1'b0, 1'b1});
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("fa_lh_resp", {resp_valid, resp_rdata, misalign_err}, {1'b1, 32'hFFFF_9A00, 1'b0});
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the EX/MEM pipeline register and the data `memory` block. Aligned loads and stores pass through in one cycle. Misaligned halfword/word accesses are split into sequential byte operations. Split load bytes are reassembled into one sign-extended result, and a `busy` stall is raised toward the pipeline while a split is in progress.

## Interface
- No parameters. Opcode encodings are the `LoadByte/LoadHalfWord/LoadWord/StoreByte/StoreHalfWord/StoreWord` macros from `mem.vh`; bit 2 = 0 means store.
- `clk` in 1: the block's single clock. All state updates on the rising edge.
- `nrst` in 1: reset. Asynchronous, active-low.
- `req_valid` in 1: an access request is presented this cycle.
- `req_op` in 3: access opcode (`mem.vh` encoding).
- `req_addr` in 11: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `busy` out 1: upstream must hold `req_*` stable. Combinational.
- `resp_valid` out 1: load result valid this cycle.
- `resp_rdata` out 32: load result, sign-extended.
- `misalign_err` out 1: misaligned access was not split (only without the macro, see Configuration).
- `mem_stall` out 1: drives `memory.stall`; 1 = no access.
- `mem_op` out 3: drives `memory.op_code`.
- `mem_addr` out 11: drives `memory.rwaddr`.
- `mem_wdata` out 32: drives `memory.wdata`.
- `mem_rdata` in 32: from `memory.rdata`, valid one cycle after the access is issued.

## Operation
- Misaligned access: halfword with `addr[0]=1`, or word with `addr[1:0]!=0`. Byte ops are aligned by definition.
- Non-load/store opcode or `req_valid=0` while IDLE:
  - `mem_stall=1`, `mem_op=LoadWord`, no response.
- Aligned access in IDLE: forward `req_op/req_addr/req_wdata` unchanged with `mem_stall=0` in the same cycle. No state change.
- Misaligned access in IDLE, with N = 2 (halfword) or 4 (word):
  - Latch op, addr and wdata.
  - Issue byte 0 in the same cycle, then go to SPLIT with `idx=1`.
- SPLIT state: each cycle issue byte `idx`, then increment `idx`. After byte N-1 is issued, return to IDLE.
- Byte k addressing: address `addr+k` modulo 2^11, so 0x7FF+1 wraps to 0x000. Crossing 0x3FF→0x400 needs no special handling.
- Split stores: each byte op is `mem_op=StoreByte` with `mem_wdata={24'b0, wdata[8k+7:8k]}` (little-endian).
- Split loads: each byte op is `mem_op=LoadByte`. Each returned `mem_rdata[7:0]` is captured into byte lane k of an assembly register.
  - Halfword result: sign-extended from byte 1.
  - Word result: bytes 3..0 concatenated.
- `busy`: 1 during a misaligned request's first cycle and in SPLIT for every cycle except the one issuing byte N-1. While `busy=1`, `req_*` is ignored.
- Reset at any time:
  - State returns to IDLE; `idx=0`; the assembly register is cleared.
  - Any in-flight load is discarded, with no `resp_valid`.
- Reset values: `busy=0`, `resp_valid=0`, `resp_rdata=0`, `misalign_err=0`, `mem_stall=1`, `mem_op=LoadWord`, `mem_addr=0`, `mem_wdata=0`.

## Timing
- Aligned load accepted in cycle T: `resp_valid=1` in T+1, with `resp_rdata=mem_rdata` passed through.
- Aligned store: 1 cycle; no response.
- Split access accepted in T: byte ops are issued in cycles T..T+N-1, and `busy` is high in T..T+N-2.
  - Next request is accepted in T+N.
- Split load result: `resp_valid=1` in T+N, with `resp_rdata` assembled combinationally from the register and the final `mem_rdata[7:0]`.
- Aligned load issued in T+N while the split response is in T+N: not possible, because the next request's response lands at T+N+1.
- `resp_valid` is a 1-cycle pulse. There is no backpressure on responses.

## Configuration
- `LSU_MISALIGN_EN` defined: split behaviour as above; `misalign_err` is tied to 0.
- Not defined:
  - There is no SPLIT state and `busy` is tied to 0.
  - A misaligned access is issued in one cycle with address low bits cleared to natural alignment: `addr[0]` for halfword, `addr[1:0]` for word.
  - `misalign_err=1` in the issuing cycle.

## Test plan
- Reset, then aligned LoadWord at 0x010 with memory word 0x8000_1234 → `mem_stall=0` in T; `resp_valid=1` and `resp_rdata=0x8000_1234` in T+1; `busy` never set.
- StoreWord 0xAABBCCDD at 0x021 (misaligned) → four StoreByte ops:
  - cycles T..T+3 at 0x021/0x022/0x023/0x024, data 0xDD/0xCC/0xBB/0xAA;
  - `busy=1` in T..T+2;
  - readback LoadWord at 0x020 and 0x024 confirms placement.
- LoadHalfWord at 0x3FF, bytes 0x34@0x3FF and 0x92@0x400 (bank boundary) → `resp_rdata=0xFFFF_9234` in T+2.
- LoadWord at 0x7FE (wrap), bytes 0x11,0x22 at 0x7FE/0x7FF and 0x33,0x44 at 0x000/0x001 → `mem_addr` sequence 0x7FE, 0x7FF, 0x000, 0x001; `resp_rdata=0x4433_2211` in T+4.
- Assert `nrst=0` during cycle T+2 of a split word load → all outputs return to reset values, no `resp_valid`; an aligned load after release completes normally.
- Build without `LSU_MISALIGN_EN`: LoadWord at 0x013 → single access at 0x010, `misalign_err=1` for one cycle, `busy=0`.
